// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: load width encodings,
// controller states and the latched request record.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

    function automatic logic is_store(input logic [3:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the execute stage (master) and the
// data-memory responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_funct3,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_funct3,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a memory word and extends it;
// flags misaligned accesses and unsupported load encodings.
module load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h0, byte_sel};
            F3_LH: begin
                misalign = addr_lo[0];
                data     = {{16{half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                misalign = addr_lo[0];
                data     = {16'h0, half_sel};
            end
            F3_LW: begin
                misalign = (addr_lo != 2'b00);
                data     = word;
            end
            default: misalign = 1'b1;
        endcase
        if (misalign) begin
            data = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory model: accepts one request in IDLE, waits LAT
// cycles, then commits the store or returns the extended load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter int unsigned  LAT         = 2,
    parameter logic [31:0]  BASE_ADDR   = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_CNT = 4'(LAT);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             below_base;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             store_req;
    logic [31:0]      rd_word;
    logic [31:0]      ext_data;
    logic             misalign;
    logic             resp_err;
    logic             mem_wr;

    // Word offset from the base; the borrow out marks addresses below the base.
    assign {below_base, word_off} = {1'b0, req_q.addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign idx       = word_off[IDX_W-1:0];
    assign in_range  = !below_base && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    assign store_req = is_store(req_q.we);
    assign rd_word   = mem[idx];
    assign resp_err  = !in_range || (!store_req && misalign);

    load_extract u_load_extract (
        .word     (rd_word),
        .addr_lo  (req_q.addr[1:0]),
        .funct3   (req_q.funct3),
        .data     (ext_data),
        .misalign (misalign)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = reset;
                if (bus.req_valid) begin
                    req_d   = '{addr:   bus.req_addr,
                                we:     bus.req_we,
                                wdata:  bus.req_wdata,
                                funct3: bus.req_funct3};
                    cnt_d   = LAT_CNT;
                    state_d = (LAT_CNT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = resp_err;
                bus.resp_rdata = (!resp_err && !store_req) ? ext_data : '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Gating with reset drops a store whose RESP cycle coincides with reset.
    assign mem_wr = (state_q == RESP) && store_req && in_range && reset;

    // NOTE: the array has no reset; its contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.we[i]) begin
                    mem[idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
